// File: rtl/spi_xfer_ctrl.sv
// Sequencing FSM for the SPI memory datapath: counts address/data bits on the
// conditioned SCLK edge pulses and strobes shift-register load, address latch and memory write.
module spi_xfer_ctrl #(
    parameter int WIDTH       = 8,
    parameter int MEM_LATENCY = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic cs_n,
    input  logic sclk_rise,
    input  logic sclk_fall,
    input  logic rw_bit,
    output logic sr_load,
    output logic addr_we,
    output logic dm_we,
    output logic miso_en,
    output logic busy
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_BIT  = CW'(WIDTH - 1);
    localparam logic [3:0]    LAST_WAIT = 4'(MEM_LATENCY - 1);

    typedef enum logic [3:0] {
        IDLE,
        ADDR_SHIFT,
        ADDR_SETTLE,
        ADDR_LATCH,
        READ_WAIT,
        READ_LOAD,
        READ_SHIFT,
        WRITE_SHIFT,
        WRITE_SETTLE,
        WRITE_STORE,
        DONE
    } state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] bit_cnt;
    logic [3:0]    wait_cnt;
    logic          bit_edge;
    logic          last_bit;

    // Only the edge that belongs to the current counting state is seen.
    always_comb begin
        bit_edge = 1'b0;
        case (state)
            ADDR_SHIFT, WRITE_SHIFT: bit_edge = sclk_rise;
            READ_SHIFT:              bit_edge = sclk_fall;
            default:                 bit_edge = 1'b0;
        endcase
        last_bit = bit_edge && (bit_cnt == LAST_BIT);
    end

    always_comb begin
        state_nxt = state;
        if (state != IDLE && cs_n) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:         if (!cs_n) state_nxt = ADDR_SHIFT;
                ADDR_SHIFT:   if (last_bit) state_nxt = ADDR_SETTLE;
                ADDR_SETTLE:  state_nxt = ADDR_LATCH;
                ADDR_LATCH:   state_nxt = rw_bit ? READ_WAIT : WRITE_SHIFT;
                READ_WAIT:    if (wait_cnt == LAST_WAIT) state_nxt = READ_LOAD;
                READ_LOAD:    state_nxt = READ_SHIFT;
                READ_SHIFT:   if (last_bit) state_nxt = DONE;
                WRITE_SHIFT:  if (last_bit) state_nxt = WRITE_SETTLE;
                WRITE_SETTLE: state_nxt = WRITE_STORE;
                WRITE_STORE:  state_nxt = DONE;
                DONE:         state_nxt = DONE;
                default:      state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Both counters restart on any state change, so every counting state starts from 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt  <= '0;
            wait_cnt <= '0;
        end else if (state_nxt != state) begin
            bit_cnt  <= '0;
            wait_cnt <= '0;
        end else begin
            if (bit_edge)           bit_cnt  <= bit_cnt + CW'(1);
            if (state == READ_WAIT) wait_cnt <= wait_cnt + 4'd1;
        end
    end

    assign addr_we = (state == ADDR_LATCH);
    assign sr_load = (state == READ_LOAD);
    assign miso_en = (state == READ_SHIFT);
    assign dm_we   = (state == WRITE_STORE);
    assign busy    = (state != IDLE);

endmodule

// File: tb/tb_spi_xfer_ctrl.sv
// Directed bench for spi_xfer_ctrl: one instance with MEM_LATENCY=1 and one with
// MEM_LATENCY=3 share stimulus; strobe cycles are logged and compared to hand-derived values.
module tb_spi_xfer_ctrl;

    logic clk = 1'b0;
    logic rst_n, cs_n, sclk_rise, sclk_fall, rw_bit;
    logic [1:0] sr_load, addr_we, dm_we, miso_en, busy;

    int cyc = 0;
    int n_tests = 0, n_fail = 0;
    int n_a[2], n_s[2], n_d[2], n_m[2];
    int c_a[2], c_s[2], c_d[2], c_mf[2], c_ml[2];
    int b_a[2], b_s[2], b_d[2], b_m[2];
    logic [1:0] miso_prev = 2'b00;
    int last;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    spi_xfer_ctrl #(.WIDTH(8), .MEM_LATENCY(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .cs_n(cs_n), .sclk_rise(sclk_rise), .sclk_fall(sclk_fall),
        .rw_bit(rw_bit), .sr_load(sr_load[0]), .addr_we(addr_we[0]), .dm_we(dm_we[0]),
        .miso_en(miso_en[0]), .busy(busy[0]));

    spi_xfer_ctrl #(.WIDTH(8), .MEM_LATENCY(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .cs_n(cs_n), .sclk_rise(sclk_rise), .sclk_fall(sclk_fall),
        .rw_bit(rw_bit), .sr_load(sr_load[1]), .addr_we(addr_we[1]), .dm_we(dm_we[1]),
        .miso_en(miso_en[1]), .busy(busy[1]));

    initial begin
        for (int i = 0; i < 2; i++) begin
            n_a[i] = 0; n_s[i] = 0; n_d[i] = 0; n_m[i] = 0;
            c_a[i] = -1; c_s[i] = -1; c_d[i] = -1; c_mf[i] = -1; c_ml[i] = -1;
        end
    end

    // Strobe monitor: cycle index is the number of posedges seen so far.
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (addr_we[i]) begin n_a[i]++; c_a[i] = cyc; end
            if (sr_load[i]) begin n_s[i]++; c_s[i] = cyc; end
            if (dm_we[i])   begin n_d[i]++; c_d[i] = cyc; end
            if (miso_en[i]) begin
                if (!miso_prev[i]) c_mf[i] = cyc;
                c_ml[i] = cyc;
                n_m[i]++;
            end
            miso_prev[i] = miso_en[i];
        end
    end

    task automatic chk(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic snap();
        for (int i = 0; i < 2; i++) begin
            b_a[i] = n_a[i]; b_s[i] = n_s[i]; b_d[i] = n_d[i]; b_m[i] = n_m[i];
        end
    endtask

    task automatic rise();
        sclk_rise = 1'b1; last = cyc; tick(); sclk_rise = 1'b0; tick();
    endtask

    task automatic fall();
        sclk_fall = 1'b1; last = cyc; tick(); sclk_fall = 1'b0; tick();
    endtask

    // Address phase; returns in the settle cycle (cycle k+1, k = 8th pulse cycle).
    task automatic do_addr(input logic rw, output int k);
        cs_n = 1'b0; rw_bit = rw; tick();
        repeat (8) rise();
        k = last;
    endtask

    task automatic do_write(input string tag);
        int k, dk;
        snap();
        do_addr(1'b0, k);
        tick(); tick();
        repeat (8) rise();
        dk = last;
        tick(); tick();
        for (int i = 0; i < 2; i++) begin
            chk({tag, "_addr_we_n"}, n_a[i] - b_a[i], 1);
            chk({tag, "_addr_we_cyc"}, c_a[i], k + 2);
            chk({tag, "_dm_we_n"}, n_d[i] - b_d[i], 1);
            chk({tag, "_dm_we_cyc"}, c_d[i], dk + 2);
            chk({tag, "_miso_n"}, n_m[i] - b_m[i], 0);
            chk({tag, "_sr_load_n"}, n_s[i] - b_s[i], 0);
            chk({tag, "_busy_done"}, int'(busy[i]), 1);
        end
        cs_n = 1'b1; tick();
        chk({tag, "_busy_end"}, int'(busy), 0);
    endtask

    // Read with stray rise pulses in settle, wait and done states.
    task automatic do_read(input string tag);
        int k, lf;
        snap();
        do_addr(1'b1, k);
        sclk_rise = 1'b1; tick(); sclk_rise = 1'b0; tick();
        sclk_rise = 1'b1; tick(); sclk_rise = 1'b0;
        tick(); tick(); tick();
        sclk_rise = 1'b1;
        fall();
        repeat (7) fall();
        lf = last;
        chk({tag, "_miso_off"}, int'(miso_en), 0);
        fall(); rise(); fall();
        chk({tag, "_addr_we_cyc1"}, c_a[0], k + 2);
        chk({tag, "_addr_we_cyc3"}, c_a[1], k + 2);
        chk({tag, "_sr_load_cyc1"}, c_s[0], c_a[0] + 2);
        chk({tag, "_sr_load_cyc3"}, c_s[1], c_a[1] + 4);
        chk({tag, "_miso_first1"}, c_mf[0], k + 5);
        chk({tag, "_miso_first3"}, c_mf[1], k + 7);
        for (int i = 0; i < 2; i++) begin
            chk({tag, "_addr_we_n"}, n_a[i] - b_a[i], 1);
            chk({tag, "_sr_load_n"}, n_s[i] - b_s[i], 1);
            chk({tag, "_miso_last"}, c_ml[i], lf);
            chk({tag, "_dm_we_n"}, n_d[i] - b_d[i], 0);
            chk({tag, "_busy_done"}, int'(busy[i]), 1);
        end
        chk({tag, "_miso_len1"}, n_m[0] - b_m[0], lf - (k + 5) + 1);
        cs_n = 1'b1; tick();
        chk({tag, "_busy_end"}, int'(busy), 0);
    endtask

    initial begin
        int k;
        rst_n = 1'b0; cs_n = 1'b1; sclk_rise = 1'b0; sclk_fall = 1'b0; rw_bit = 1'b0;
        repeat (3) tick();
        chk("reset_outs", int'({busy, addr_we, sr_load, dm_we, miso_en}), 0);
        rst_n = 1'b1; tick(); tick();
        chk("idle_cs_high", int'(busy), 0);

        do_write("wr");

        // Abort on the same cycle as the 8th address edge: no address latch.
        snap();
        cs_n = 1'b0; tick();
        repeat (7) rise();
        sclk_rise = 1'b1; cs_n = 1'b1; tick(); sclk_rise = 1'b0;
        chk("abort_addr_busy", int'(busy), 0);
        repeat (3) tick();
        chk("abort_addr_we_n", n_a[0] - b_a[0], 0);

        // Abort on the same cycle as the 5th data edge of a write.
        snap();
        do_addr(1'b0, k);
        tick(); tick();
        repeat (4) rise();
        sclk_rise = 1'b1; cs_n = 1'b1; tick(); sclk_rise = 1'b0;
        chk("abort_wr_busy", int'(busy), 0);
        repeat (3) tick();
        chk("abort_wr_dm_we_n", n_d[0] - b_d[0], 0);
        chk("abort_wr_addr_we_n", n_a[0] - b_a[0], 1);

        // Next transfer after the abort still needs exactly 8 edges per phase.
        do_read("rd");

        // Back-to-back read then write with a single cs_n-high cycle between.
        do_read("b2b_rd");
        do_write("b2b_wr");

        // Reset in the middle of the read data phase.
        do_addr(1'b1, k);
        repeat (6) tick();
        repeat (3) fall();
        chk("pre_reset_miso", int'(miso_en), 3);
        #2 rst_n = 1'b0;
        #1 chk("async_reset_outs", int'({busy, addr_we, sr_load, dm_we, miso_en}), 0);
        cs_n = 1'b1;
        tick();
        rst_n = 1'b1; tick(); tick();
        chk("post_reset_idle", int'(busy), 0);

        do_write("post_rst_wr");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, expected finish");
        $fatal(1);
    end

endmodule

// File: doc/spi_xfer_ctrl.md
Name: spi_xfer_ctrl

Overview:
Sequencing FSM for the SPI memory datapath. Tracks chip select and the conditioned SCLK edge pulses, counts bits in the address and data phases, and drives the parallel-load control of the shift register. Also drives the address-latch write enable, the data-memory write enable and the MISO tri-state enable. Sits between the input conditioners and the shift register, address latch and data memory.

Parameters:
WIDTH, 8, bits per phase (address+R/W phase and data phase); shift register width.
MEM_LATENCY, 1, cycles from addr_we to valid memory read data; legal range 1..15.

Ports:
clk  in  1  FPGA clock; all state changes on posedge
rst_n  in  1  asynchronous active-low reset
cs_n  in  1  conditioned chip select, active low
sclk_rise  in  1  one-cycle pulse, SCLK positive-edge indicator (same pulse feeds shift register shift)
sclk_fall  in  1  one-cycle pulse, SCLK negative-edge indicator
rw_bit  in  1  shift register parallel output bit 0 (1 = read, 0 = write)
sr_load  out  1  shift register parallel-load strobe
addr_we  out  1  address latch write enable
dm_we  out  1  data memory write enable
miso_en  out  1  MISO output buffer enable
busy  out  1  high in every state except IDLE

Behaviour:
- Reset: async on rst_n low. State IDLE, bit counter 0, all outputs 0. Release takes effect at the next clk edge.
- Outputs are Moore, decoded from the state register only. Each strobe is exactly one clk cycle wide.
- Bit counter: $clog2(WIDTH+1) bits. Cleared on entry to every counting state. Increments only on the qualifying edge pulse in that state.
- IDLE: cs_n==0 -> ADDR_SHIFT.
- ADDR_SHIFT: count sclk_rise. On the cycle the WIDTH-th pulse is seen -> ADDR_SETTLE.
- ADDR_SETTLE: one cycle so shift register parallel output catches up (two-register lag) -> ADDR_LATCH.
- ADDR_LATCH: addr_we=1; sample rw_bit. 1 -> READ_WAIT; 0 -> WRITE_SHIFT.
- READ_WAIT: hold MEM_LATENCY cycles (wait counter) -> READ_LOAD.
- READ_LOAD: sr_load=1 for one cycle -> READ_SHIFT.
- READ_SHIFT: miso_en=1. Count sclk_fall. On the WIDTH-th pulse -> DONE.
- WRITE_SHIFT: count sclk_rise. On the WIDTH-th pulse -> WRITE_SETTLE.
- WRITE_SETTLE: one cycle -> WRITE_STORE.
- WRITE_STORE: dm_we=1 for one cycle -> DONE.
- DONE: all strobes 0; busy=1. Waits for cs_n==1 -> IDLE. sclk edges ignored.
- Abort: cs_n==1 in any non-IDLE state -> IDLE next cycle. Abort has priority over every other transition, including a same-cycle WIDTH-th edge. An aborted write never asserts dm_we. If abort occurs in ADDR_SHIFT/ADDR_SETTLE, addr_we is not asserted.
- Edges arriving in non-counting states (SETTLE, LATCH, WAIT, LOAD, STORE, DONE, IDLE) are ignored and not counted.
- sclk_rise and sclk_fall in the same cycle: only the pulse qualifying for the current state counts.
- Latency: addr_we asserts 2 cycles after the cycle carrying the WIDTH-th address sclk_rise. sr_load asserts MEM_LATENCY+1 cycles after addr_we. dm_we asserts 2 cycles after the WIDTH-th data sclk_rise.
- Reset mid-transfer: immediate IDLE; outputs drop asynchronously.

Test Plan:
- Reset: rst_n low mid-READ_SHIFT -> sr_load, addr_we, dm_we, miso_en, busy all 0 in the same cycle; state IDLE after release.
- Write transfer, WIDTH=8: cs_n low, 8 sclk_rise with rw_bit=0 at latch, 8 more sclk_rise -> addr_we one pulse 2 cycles after 8th edge; dm_we one pulse 2 cycles after 16th edge; miso_en never high; busy until cs_n high.
- Read transfer, MEM_LATENCY=1: 8 sclk_rise, rw_bit=1 -> addr_we pulse, sr_load pulse 2 cycles later. miso_en high from the cycle after sr_load until the 8th subsequent sclk_fall; then DONE, miso_en 0.
- Abort: cs_n high on the same cycle as the 5th data sclk_rise of a write -> IDLE next cycle, dm_we never asserted, counter 0 on the next transfer.
- Ignored edges: sclk_rise pulses during ADDR_SETTLE/READ_WAIT and in DONE -> no counter change; the following transfer still needs exactly 8 edges per phase.
- MEM_LATENCY=3, back-to-back read then write with one idle cycle of cs_n high between -> sr_load 4 cycles after addr_we; second transfer starts cleanly from IDLE.
